// File: rtl/l2_learn_pkg.sv
// Shared types and helpers for the layer-2 online learning unit.
// Holds the controller state encoding and the field-index arithmetic
// used to address the packed weight, trace, threshold and leak buses.
package l2_learn_pkg;

  localparam int N_NEUR      = 3;
  localparam int N_SYN       = 6;
  localparam int P_WIDTH_DEF = 9;

  typedef enum logic [2:0] {
    IDLE,
    WUPD,
    THUPD,
    DECAY,
    DONE
  } lu_state_e;

  // Flat field index of (neuron, synapse) in the packed weight bus, both 0-based
  function automatic int weightField(input int neuron, input int synapse);
    return neuron * N_SYN + synapse;
  endfunction

  // LSB position of a field inside any packed bus of equal-width fields
  function automatic int fieldLsb(input int field, input int width);
    return field * width;
  endfunction

  // Trace fields carry one more bit than weights so they can exceed the weight range
  function automatic int traceWidth(input int weightWidth);
    return weightWidth + 1;
  endfunction

endpackage

// File: rtl/l2_lu_update.sv
// Saturating "move toward target" step: next = clip(cur + ((target - cur) >>> shift)).
// The difference is signed and the shift is arithmetic, so a negative step
// rounds toward minus infinity.
module l2_lu_update #(
  parameter int p_w     = 9,
  parameter int p_shift = 2
) (
  input  logic [p_w-1:0] cur_i,
  input  logic [p_w-1:0] target_i,
  output logic [p_w-1:0] next_o
);

  // Two guard bits: one for sign, one to catch overshoot above the unsigned maximum
  logic signed [p_w+1:0] diff;
  logic signed [p_w+1:0] step;
  logic signed [p_w+1:0] sum;

  // Compute the step and clip the result into [0, 2^p_w - 1]
  always_comb begin
    diff = $signed({2'b00, target_i}) - $signed({2'b00, cur_i});
    step = diff >>> p_shift;
    sum  = $signed({2'b00, cur_i}) + step;
    if (sum[p_w+1]) begin
      next_o = '0;
    end else if (sum[p_w]) begin
      next_o = '1;
    end else begin
      next_o = sum[p_w-1:0];
    end
  end

endmodule

// File: rtl/l2_learning_unit.sv
// Online learning engine for the 3-neuron, 6-input second layer.
// On a winning spike it walks the winner's six weights toward the captured
// traces, then moves its threshold toward the captured leak value. An input
// event followed by a spike-free window triggers a floor-limited decay of
// all thresholds.
module l2_learning_unit
  import l2_learn_pkg::*;
#(
  parameter int p_width    = P_WIDTH_DEF,
  parameter int p_th_width = 2 * p_width + 4,
  parameter int p_eta_w    = 2,
  parameter int p_eta_th   = 3,
  parameter int p_win      = 64,
  parameter int p_th_dec   = 16,
  parameter int p_th_min   = 32
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_learn_en,
  input  logic                                 i_load,
  input  logic [N_NEUR*N_SYN*p_width-1:0]      i_weight_init,
  input  logic [N_NEUR*p_th_width-1:0]         i_threshold_init,
  input  logic                                 i_event,
  input  logic [N_NEUR-1:0]                    i_spike,
  input  logic [N_SYN*traceWidth(p_width)-1:0] i_tr,
  input  logic [N_NEUR*p_th_width-1:0]         i_lv,
  output logic [N_NEUR*N_SYN*p_width-1:0]      o_weight,
  output logic [N_NEUR*p_th_width-1:0]         o_threshold,
  output logic                                 o_busy,
  output logic                                 o_update_done
);

  localparam int TR_W  = traceWidth(p_width);
  localparam int CNT_W = (p_win > 2) ? $clog2(p_win) : 1;

  localparam logic [2:0]            LAST_SYN = 3'(N_SYN - 1);
  localparam logic [CNT_W-1:0]      WIN_LAST = CNT_W'(p_win - 1);
  localparam logic [p_width-1:0]    W_MAX    = '1;
  localparam logic [p_th_width-1:0] TH_MIN   = p_th_width'(p_th_min);
  localparam logic [p_th_width-1:0] TH_DEC   = p_th_width'(p_th_dec);
  localparam logic [p_th_width-1:0] TH_KNEE  = p_th_width'(p_th_min + p_th_dec);

  lu_state_e                         state_q, state_d;
  logic [2:0]                        synCnt_q, synCnt_d;
  logic [1:0]                        winner_q, winner_d;
  logic [N_SYN*TR_W-1:0]             trCap_q, trCap_d;
  logic [p_th_width-1:0]             lvCap_q, lvCap_d;
  logic [N_NEUR*N_SYN*p_width-1:0]   weight_q, weight_d;
  logic [N_NEUR*p_th_width-1:0]      threshold_q, threshold_d;
  logic                              busy_q, done_q;
  logic                              winActive_q, winActive_d;
  logic [CNT_W-1:0]                  winCnt_q, winCnt_d;
  logic                              decayPending_q, decayPending_d;

  logic [1:0]                        spikeWinner;
  int                                wField;
  logic [TR_W-1:0]                   trSel;
  logic [p_width-1:0]                trSat;
  logic [p_width-1:0]                wCur, wNew;
  logic [p_th_width-1:0]             thCur, thNew;
  logic [N_NEUR*p_th_width-1:0]      thDecayed;
  logic [p_th_width-1:0]             thOld;

  // Lowest-index spiking neuron wins when several fire together
  always_comb begin
    if (i_spike[0]) begin
      spikeWinner = 2'd0;
    end else if (i_spike[1]) begin
      spikeWinner = 2'd1;
    end else begin
      spikeWinner = 2'd2;
    end
  end

  // Select the active synapse of the winner and clamp its trace to the weight range
  always_comb begin
    wField = weightField(int'(winner_q), int'(synCnt_q));
    trSel  = trCap_q[fieldLsb(int'(synCnt_q), TR_W) +: TR_W];
    trSat  = trSel[TR_W-1] ? W_MAX : trSel[p_width-1:0];
    wCur   = weight_q[fieldLsb(wField, p_width) +: p_width];
    thCur  = threshold_q[fieldLsb(int'(winner_q), p_th_width) +: p_th_width];
  end

  l2_lu_update #(
    .p_w    (p_width),
    .p_shift(p_eta_w)
  ) u_weightStep (
    .cur_i   (wCur),
    .target_i(trSat),
    .next_o  (wNew)
  );

  l2_lu_update #(
    .p_w    (p_th_width),
    .p_shift(p_eta_th)
  ) u_thresholdStep (
    .cur_i   (thCur),
    .target_i(lvCap_q),
    .next_o  (thNew)
  );

  // Decay every threshold by a fixed step, stopping at the floor; values already below the floor stay put
  always_comb begin
    thDecayed = threshold_q;
    thOld     = '0;
    for (int n = 0; n < N_NEUR; n++) begin
      thOld = threshold_q[n*p_th_width +: p_th_width];
      if (thOld < TH_MIN) begin
        thDecayed[n*p_th_width +: p_th_width] = thOld;
      end else if (thOld < TH_KNEE) begin
        thDecayed[n*p_th_width +: p_th_width] = TH_MIN;
      end else begin
        thDecayed[n*p_th_width +: p_th_width] = thOld - TH_DEC;
      end
    end
  end

  // Controller next state and datapath updates; load overrides everything and aborts a running update
  always_comb begin
    state_d     = state_q;
    synCnt_d    = synCnt_q;
    winner_d    = winner_q;
    trCap_d     = trCap_q;
    lvCap_d     = lvCap_q;
    weight_d    = weight_q;
    threshold_d = threshold_q;
    if (i_load) begin
      weight_d    = i_weight_init;
      threshold_d = i_threshold_init;
      synCnt_d    = '0;
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_learn_en && (|i_spike)) begin
            winner_d = spikeWinner;
            trCap_d  = i_tr;
            lvCap_d  = i_lv[fieldLsb(int'(spikeWinner), p_th_width) +: p_th_width];
            synCnt_d = '0;
            state_d  = WUPD;
          end else if (i_learn_en && decayPending_q) begin
            state_d = DECAY;
          end
        end
        WUPD: begin
          weight_d[fieldLsb(wField, p_width) +: p_width] = wNew;
          if (synCnt_q == LAST_SYN) begin
            state_d = THUPD;
          end else begin
            synCnt_d = synCnt_q + 3'd1;
          end
        end
        THUPD: begin
          threshold_d[fieldLsb(int'(winner_q), p_th_width) +: p_th_width] = thNew;
          state_d = DONE;
        end
        DECAY: begin
          threshold_d = thDecayed;
          state_d     = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // No-spike window: an event arms it, a spike disarms it, running out of cycles requests a decay
  always_comb begin
    winActive_d    = winActive_q;
    winCnt_d       = winCnt_q;
    decayPending_d = decayPending_q;
    if (i_load) begin
      winActive_d    = 1'b0;
      winCnt_d       = '0;
      decayPending_d = 1'b0;
    end else begin
      if (state_q == DECAY) begin
        decayPending_d = 1'b0;
      end
      if (winActive_q) begin
        if (|i_spike) begin
          winActive_d = 1'b0;
          winCnt_d    = '0;
        end else if (winCnt_q == WIN_LAST) begin
          winActive_d    = 1'b0;
          winCnt_d       = '0;
          decayPending_d = 1'b1;
        end else begin
          winCnt_d = winCnt_q + CNT_W'(1);
        end
      end else if (i_event) begin
        winActive_d = 1'b1;
        winCnt_d    = '0;
      end
    end
  end

  // State and datapath registers; busy and done are registered from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= IDLE;
      synCnt_q       <= '0;
      winner_q       <= '0;
      trCap_q        <= '0;
      lvCap_q        <= '0;
      weight_q       <= '0;
      threshold_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      winActive_q    <= 1'b0;
      winCnt_q       <= '0;
      decayPending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      synCnt_q       <= synCnt_d;
      winner_q       <= winner_d;
      trCap_q        <= trCap_d;
      lvCap_q        <= lvCap_d;
      weight_q       <= weight_d;
      threshold_q    <= threshold_d;
      busy_q         <= (state_d != IDLE);
      done_q         <= (state_d == DONE);
      winActive_q    <= winActive_d;
      winCnt_q       <= winCnt_d;
      decayPending_q <= decayPending_d;
    end
  end

  assign o_weight      = weight_q;
  assign o_threshold   = threshold_q;
  assign o_busy        = busy_q;
  assign o_update_done = done_q;

endmodule

// File: tb/tb_l2_learning_unit.sv
// Directed testbench for l2_learning_unit with hand-computed expected values.
module tb_l2_learning_unit;

  localparam int P_W  = 9;
  localparam int TH_W = 2 * P_W + 4;
  localparam int NW   = 3 * 6 * P_W;
  localparam int NT   = 3 * TH_W;
  localparam int NTR  = 6 * (P_W + 1);

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_learn_en;
  logic          i_load;
  logic [NW-1:0] i_weight_init;
  logic [NT-1:0] i_threshold_init;
  logic          i_event;
  logic [2:0]    i_spike;
  logic [NTR-1:0] i_tr;
  logic [NT-1:0] i_lv;
  logic [NW-1:0] o_weight;
  logic [NT-1:0] o_threshold;
  logic          o_busy;
  logic          o_update_done;

  int checks    = 0;
  int failures  = 0;
  int doneSeen  = 0;

  int expN1[6] = '{70, 71, 72, 73, 73, 74};
  int expN2[6] = '{150, 502, 15, 511, 0, 7};

  l2_learning_unit dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_learn_en      (i_learn_en),
    .i_load          (i_load),
    .i_weight_init   (i_weight_init),
    .i_threshold_init(i_threshold_init),
    .i_event         (i_event),
    .i_spike         (i_spike),
    .i_tr            (i_tr),
    .i_lv            (i_lv),
    .o_weight        (o_weight),
    .o_threshold     (o_threshold),
    .o_busy          (o_busy),
    .o_update_done   (o_update_done)
  );

  // Free-running clock
  always #5 i_clk = ~i_clk;

  // Hard time limit so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [P_W-1:0] getW(input int n, input int s);
    return o_weight[(6*(n-1)+(s-1))*P_W +: P_W];
  endfunction

  function automatic logic [TH_W-1:0] getTh(input int n);
    return o_threshold[(n-1)*TH_W +: TH_W];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic stepWatch(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (o_update_done) doneSeen++;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] spk, input logic ev);
    i_spike = spk;
    i_event = ev;
    step();
    i_spike = 3'b000;
    i_event = 1'b0;
  endtask

  task automatic loadInit(input int th1, input int th2, input int th3);
    for (int n = 1; n <= 3; n++)
      for (int s = 1; s <= 6; s++)
        i_weight_init[(6*(n-1)+(s-1))*P_W +: P_W] = P_W'(50 + 10*n + s);
    i_weight_init[(6+0)*P_W +: P_W] = 9'd100;
    i_weight_init[(6+1)*P_W +: P_W] = 9'd500;
    i_weight_init[(6+2)*P_W +: P_W] = 9'd20;
    i_weight_init[(6+3)*P_W +: P_W] = 9'd511;
    i_weight_init[(6+4)*P_W +: P_W] = 9'd1;
    i_weight_init[(6+5)*P_W +: P_W] = 9'd8;
    i_threshold_init = {TH_W'(th3), TH_W'(th2), TH_W'(th1)};
    i_load = 1'b1;
    step();
    i_load = 1'b0;
  endtask

  task automatic setTest1Inputs();
    i_tr = {10'd5, 10'd0, 10'd1023, 10'd0, 10'd512, 10'd300};
    i_lv = {22'd7, 22'd1600, 22'd9999};
  endtask

  initial begin
    i_rst = 1'b1;
    i_learn_en = 1'b0;
    i_load = 1'b0;
    i_weight_init = '0;
    i_threshold_init = '0;
    i_event = 1'b0;
    i_spike = 3'b000;
    i_tr = '0;
    i_lv = '0;

    // Reset state
    step();
    step();
    i_rst = 1'b0;
    checkOutput("rstWeightZero", 64'(o_weight == '0), 64'd1);
    checkOutput("rstThZero", 64'(o_threshold == '0), 64'd1);
    checkOutput("rstBusy", 64'(o_busy), 64'd0);
    checkOutput("rstDone", 64'(o_update_done), 64'd0);

    // Weight rise, saturation, fall, no wrap
    loadInit(1000, 2000, 3000);
    checkOutput("loadW21", 64'(getW(2, 1)), 64'd100);
    setTest1Inputs();
    i_learn_en = 1'b1;
    applyStimulus(3'b010, 1'b0);
    i_tr = '0;
    i_lv = '0;
    checkOutput("e0Busy", 64'(o_busy), 64'd1);
    checkOutput("e0W21", 64'(getW(2, 1)), 64'd100);
    step();
    checkOutput("e1W21", 64'(getW(2, 1)), 64'd150);
    checkOutput("e1W22", 64'(getW(2, 2)), 64'd500);
    repeat (5) step();
    for (int s = 1; s <= 6; s++)
      checkOutput($sformatf("e6W2%0d", s), 64'(getW(2, s)), 64'(expN2[s-1]));
    checkOutput("e6Done", 64'(o_update_done), 64'd0);
    checkOutput("e6Th2", 64'(getTh(2)), 64'd2000);
    step();
    checkOutput("e7Th2", 64'(getTh(2)), 64'd1950);
    checkOutput("e7Th1", 64'(getTh(1)), 64'd1000);
    checkOutput("e7Done", 64'(o_update_done), 64'd1);
    step();
    checkOutput("e8Done", 64'(o_update_done), 64'd0);
    checkOutput("e8Busy", 64'(o_busy), 64'd0);
    for (int s = 1; s <= 6; s++) begin
      checkOutput($sformatf("keepW1%0d", s), 64'(getW(1, s)), 64'(60 + s));
      checkOutput($sformatf("keepW3%0d", s), 64'(getW(3, s)), 64'(80 + s));
    end

    // Threshold move and lowest-index tie-break
    i_tr = {6{10'd100}};
    i_lv = {22'd7, 22'd1600, 22'd1400};
    applyStimulus(3'b011, 1'b0);
    repeat (7) step();
    checkOutput("tieTh1", 64'(getTh(1)), 64'd1050);
    checkOutput("tieTh2", 64'(getTh(2)), 64'd1950);
    checkOutput("tieDone", 64'(o_update_done), 64'd1);
    for (int s = 1; s <= 6; s++)
      checkOutput($sformatf("tieW1%0d", s), 64'(getW(1, s)), 64'(expN1[s-1]));
    checkOutput("tieW21", 64'(getW(2, 1)), 64'd150);
    checkOutput("tieW31", 64'(getW(3, 1)), 64'd81);

    // Decay after a spike-free window, with floor
    loadInit(100, 40, 20);
    applyStimulus(3'b000, 1'b1);
    repeat (63) step();
    step();
    checkOutput("winBusy", 64'(o_busy), 64'd0);
    step();
    checkOutput("d0Busy", 64'(o_busy), 64'd1);
    checkOutput("d0Th1", 64'(getTh(1)), 64'd100);
    step();
    checkOutput("d1Th1", 64'(getTh(1)), 64'd84);
    checkOutput("d1Th2", 64'(getTh(2)), 64'd32);
    checkOutput("d1Th3", 64'(getTh(3)), 64'd20);
    checkOutput("d1Done", 64'(o_update_done), 64'd1);
    step();
    checkOutput("d2Done", 64'(o_update_done), 64'd0);

    // Spike on the expiry cycle cancels the decay
    i_learn_en = 1'b0;
    loadInit(100, 40, 20);
    applyStimulus(3'b000, 1'b1);
    repeat (63) step();
    applyStimulus(3'b001, 1'b0);
    i_learn_en = 1'b1;
    doneSeen = 0;
    stepWatch(4);
    checkOutput("expSpikeDone", 64'(doneSeen), 64'd0);
    checkOutput("expSpikeTh1", 64'(getTh(1)), 64'd100);
    checkOutput("expSpikeTh2", 64'(getTh(2)), 64'd40);

    // Learning disabled: spikes and expired windows change nothing
    i_learn_en = 1'b0;
    loadInit(100, 40, 20);
    setTest1Inputs();
    doneSeen = 0;
    applyStimulus(3'b010, 1'b0);
    applyStimulus(3'b000, 1'b1);
    stepWatch(70);
    applyStimulus(3'b010, 1'b0);
    stepWatch(8);
    checkOutput("disDone", 64'(doneSeen), 64'd0);
    checkOutput("disW21", 64'(getW(2, 1)), 64'd100);
    checkOutput("disTh1", 64'(getTh(1)), 64'd100);
    checkOutput("disBusy", 64'(o_busy), 64'd0);
    i_learn_en = 1'b1;
    step();
    step();
    checkOutput("heldDecayTh1", 64'(getTh(1)), 64'd84);
    checkOutput("heldDecayDone", 64'(o_update_done), 64'd1);
    step();

    // Busy spike ignored, load aborts the update
    loadInit(1000, 2000, 3000);
    setTest1Inputs();
    applyStimulus(3'b010, 1'b0);
    step();
    step();
    applyStimulus(3'b001, 1'b0);
    checkOutput("e3W23", 64'(getW(2, 3)), 64'd15);
    checkOutput("e3Busy", 64'(o_busy), 64'd1);
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    checkOutput("abortW21", 64'(getW(2, 1)), 64'd100);
    checkOutput("abortW23", 64'(getW(2, 3)), 64'd20);
    checkOutput("abortTh2", 64'(getTh(2)), 64'd2000);
    checkOutput("abortBusy", 64'(o_busy), 64'd0);
    doneSeen = 0;
    stepWatch(10);
    checkOutput("abortDone", 64'(doneSeen), 64'd0);
    checkOutput("abortW11", 64'(getW(1, 1)), 64'd61);
    checkOutput("abortW24", 64'(getW(2, 4)), 64'd511);

    // Reset in the middle of an update
    applyStimulus(3'b010, 1'b0);
    step();
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    checkOutput("midRstWeight", 64'(o_weight == '0), 64'd1);
    checkOutput("midRstTh", 64'(o_threshold == '0), 64'd1);
    checkOutput("midRstBusy", 64'(o_busy), 64'd0);
    checkOutput("midRstDone", 64'(o_update_done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_learning_unit.md
# l2_learning_unit

Online learning engine for the 3-neuron, 6-input second layer. It reads the layer's trace bus (`o_tr`), leak-value bus (`o_lv`) and spike vector (`o_spike_out`). It owns and drives the layer's `i_weight` and `i_threshold` buses. On each winning spike it pulls the winner's weights and threshold toward the captured traces and leak value. When an input event produces no spike within a window, it decays all thresholds.

## Interface
Parameters:
- p_width, 9, weight width; trace width is p_width+1
- p_th_width, 2*p_width+4, threshold / leak-value field width per neuron
- p_eta_w, 2, weight learning-rate shift
- p_eta_th, 3, threshold learning-rate shift
- p_win, 64, no-spike window length in cycles (≥2)
- p_th_dec, 16, threshold decay step
- p_th_min, 32, threshold decay floor

Ports:
- i_clk  in  1  clock. One clock domain.
- i_rst  in  1  reset. Synchronous, active-high.
- i_learn_en  in  1  enables weight/threshold updates and decay
- i_load  in  1  load initial weights/thresholds from init buses
- i_weight_init  in  3*6*p_width  packed like o_weight
- i_threshold_init  in  3*p_th_width  packed like o_threshold
- i_event  in  1  OR of the layer's six input events (pulse)
- i_spike  in  3  layer spike vector; bit k = neuron k+1
- i_tr  in  6*p_width+6  traces, synapse 1 in LSBs
- i_lv  in  3*p_th_width  leak values, neuron 1 in LSBs
- o_weight  out  3*6*p_width  neuron n, synapse s at field index 6*(n-1)+(s-1)
- o_threshold  out  3*p_th_width  neuron 1 in LSBs
- o_busy  out  1  update in progress
- o_update_done  out  1  one-cycle pulse at end of a winner update or decay

## Operation
- **States:** IDLE, WUPD, THUPD, DECAY, DONE.
- **IDLE → WUPD:** taken when i_learn_en=1 and i_spike≠0. On that edge:
  - capture i_tr, the winner's i_lv and the winner index;
  - if several spike bits are set, the lowest index wins.
- **WUPD:** 6 cycles, one synapse per cycle (counter 1..6). Per synapse:
  - tr_s = min(tr, 2^p_width−1);
  - w ← clip(w + ((tr_s − w) >>> p_eta_w), 0, 2^p_width−1);
  - signed arithmetic, arithmetic shift.
- **THUPD:** 1 cycle. th ← clip(th + ((lv − th) >>> p_eta_th), 0, 2^p_th_width−1).
- **DONE:** 1 cycle with o_update_done=1, then IDLE.
- **No-spike window:**
  - An i_event pulse while the window is idle starts a counter.
  - A further i_event while counting does not restart it.
  - Any i_spike bit while counting clears the window.
  - Reaching p_win cycles with no spike sets decay_pending.
  - Spike and expiry in the same cycle: the spike wins, no decay.
- **DECAY:** entered from IDLE when decay_pending=1 and i_learn_en=1.
  - All three thresholds: th ← max(th − p_th_dec, p_th_min).
  - A threshold already below p_th_min is left unchanged.
  - Clears decay_pending; next state DONE.
- **Priority in IDLE:** i_load > spike > decay.
- **Spikes while not IDLE:** ignored for learning; they still clear the window.
- **i_load (any state):**
  - copies both init buses to the output registers;
  - aborts any update in progress;
  - clears the window and decay_pending;
  - next state is IDLE.
- **i_learn_en low:** no new update or decay starts; an update already running completes.
- **Reset:** all weights and thresholds 0, state IDLE, window cleared, o_busy=0, o_update_done=0.

## Timing
- Capture edge E0. At edge Ek (k=1..6), synapse k of the winner takes its new value.
- Threshold updates at E7; o_update_done is high from E7 to E8; the block is in IDLE after E8.
- o_busy is high from E0 to E8 (states WUPD, THUPD, DONE, DECAY).
- Decay: entry edge D0, thresholds updated at D1, o_update_done high from D1 to D2.
- The window counter runs in every state, including busy states.
- All outputs are registered. Weights of non-winning neurons never change during an update.
- i_tr and i_lv are sampled only at E0; later changes do not affect the update in progress.

## Structure
- **Package `l2_learn_pkg`:** state enum; field-index helper functions for the packed weight, trace and threshold buses; width localparams derived from p_width.
- **Sub-module `l2_lu_update`:** parameterized width and shift. Implements the saturating "move toward target" step (signed difference, arithmetic shift, clip). Instantiated once for weights (synapse mux in front) and once for thresholds.
- Target size: roughly 200–300 RTL lines.

## Test plan
All scenarios use defaults (p_width=9).
- **Weight rise:** load w(n2,s1)=100; spike 3'b010 with tr1=300 → after E1, w(n2,s1)=150; other neurons unchanged; o_update_done at E7.
- **Saturation and fall:**
  - w=500, tr=512 (saturated to 511) → 502.
  - w=20, tr=0 → 15.
  - Verify no wrap at 0 or 511.
- **Threshold move and tie-break:** th1=1000, lv1=1400; spike 3'b011 → only neuron 1 updates; th1=1050 at E7.
- **Decay and floor:**
  - i_event, then 64 spike-free cycles → th 100→84, 40→32, 20 stays 20.
  - A spike arriving on the expiry cycle → no decay.
- **Busy, load abort, reset:**
  - A spike at E3 is ignored.
  - i_load at E4 → init values appear next cycle and the state returns to IDLE.
  - i_rst mid-update → all outputs 0.
- **Learn disable:** i_learn_en=0 with spikes and expired windows → no weight or threshold change, o_update_done stays 0.
